piso_serializer_tx: RTL
=======================

Name: piso_serializer_tx

Overview:
- Parallel-in/serial-out transmitter: takes WIDTH-bit words over a valid/ready handshake and drives them one bit per CLK onto a serial line, D_OUT.
- D_OUT is the data input of a downstream chain of async-reset D flip-flops (the serial receive side).
- A one-deep pending buffer allows back-to-back frames with no idle gap.
- FRAME and LAST strobes mark word boundaries for the receiver.

Parameters:
- WIDTH, 8, bits per word; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- IDLE_LEVEL, 1'b0, value driven on D_OUT when no frame is active.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- IN_DATA  input  WIDTH  parallel word to transmit.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  block can accept a word this cycle.
- D_OUT  output  1  serial data bit.
- FRAME  output  1  high while D_OUT carries a valid data bit.
- LAST  output  1  high during the final bit of each word.
- BUSY  output  1  high when the shifter or the pending buffer holds data.

Behaviour:
- Reset:
  - Asynchronous, active-high, takes effect immediately, independent of CLK.
  - While RESET=1: D_OUT=IDLE_LEVEL, FRAME=0, LAST=0, BUSY=0, IN_READY=0.
  - Shifter, pending buffer and bit counter are cleared; state goes to IDLE.
  - First CLK edge after RESET falls: IN_READY=1.
- Handshake:
  - A word is accepted on a posedge where IN_VALID=1 and IN_READY=1.
  - IN_READY is a registered output: IN_READY = !pending_full (forced 0 in reset). It has no combinational path from IN_VALID.
  - IN_DATA is ignored whenever it is not accepted.
- State machine:
  - States: IDLE, SHIFT.
  - Registers: shift register sh[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH), pending register pend plus flag pending_full.
- IDLE:
  - On accept: sh <= IN_DATA, cnt <= 0, go to SHIFT.
  - Latency is 1: the first bit appears on D_OUT in the cycle after the accept edge.
- SHIFT outputs:
  - D_OUT = sh[WIDTH-1] when MSB_FIRST, else sh[0].
  - FRAME=1; LAST = (cnt == WIDTH-1).
- SHIFT, each posedge:
  - If cnt < WIDTH-1: shift sh toward the output end by one, cnt <= cnt+1.
  - If an accept occurs on the same edge, pend <= IN_DATA and pending_full <= 1.
- SHIFT, last-bit edge (cnt == WIDTH-1):
  - pending_full=1: sh <= pend, pending_full <= 0, cnt <= 0, stay in SHIFT. The next word starts with no gap.
  - Else if an accept occurs on this edge: sh <= IN_DATA directly, cnt <= 0, stay in SHIFT. No gap, and pend is not used.
  - Else: go to IDLE. D_OUT returns to IDLE_LEVEL, FRAME=0.
- Accept/drain collision: if the pending buffer drains on the same edge a new word arrives, that cannot happen, because IN_READY was 0.
- Outside SHIFT: D_OUT=IDLE_LEVEL, FRAME=0, LAST=0.
- BUSY = (state==SHIFT) || pending_full.
- Throughput: one word per WIDTH cycles sustained; one frame in flight plus one pending.
- Reset mid-frame: the partial word is abandoned and the pending word is discarded. No resumption after release.

Decomposition:
- Package piso_serializer_pkg:
  - State typedef: enum logic {IDLE, SHIFT}.
  - Function cnt_width(WIDTH), returning $clog2(WIDTH).
- One sub-module: piso_shift_reg.
  - Handles load/shift with MSB_FIRST steering and serial-bit output.
  - Async active-high reset on CLK/RESET.
- The FSM, counter, pending buffer and handshake stay in the top level.

Test Plan:
- Reset check: hold RESET=1 for 3 cycles with IN_VALID=1 toggling. Expect D_OUT=0, FRAME=0, LAST=0, BUSY=0, IN_READY=0 throughout. Expect IN_READY=1 one edge after release.
- Single word, defaults: send 8'hA5, then IN_VALID=0. Expect D_OUT=1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept. FRAME=1 for exactly 8 cycles; LAST=1 only on the 8th; then IDLE with D_OUT=0.
- Back-to-back: hold IN_VALID=1 with 8'hF0, then 8'h0F, then 8'h81.
  - IN_READY drops after the 2nd accept and re-rises after the first frame ends.
  - FRAME stays high for 24 contiguous cycles.
  - Serial stream = F0,0F,81 MSB-first with no gap.
- Reset mid-frame: assert RESET asynchronously (between edges) during bit 4 of 8'hC3 with 8'h55 pending.
  - D_OUT, FRAME and BUSY clear immediately without waiting for a CLK edge.
  - After release, send 8'h3C: it alone is transmitted correctly.
- LSB-first: instance with MSB_FIRST=0, IDLE_LEVEL=1, WIDTH=4, sending 4'b1100. Expect D_OUT=0,0,1,1, and D_OUT=1 when idle.
- Same-edge reload: pending empty, new accept exactly on the last-bit edge of 8'h01 with IN_DATA=8'hFE. Expect 8'hFE to start the next cycle, pending_full to stay 0, and IN_READY to stay 1.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serial transmitter.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of the per-word bit counter.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register that presents one bit per clock at its output end.
// MSB_FIRST selects which end of the word leaves first.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_bit
);

    logic [WIDTH-1:0] sh;

    // Load a new word or move the current one one place toward the output end.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sh <= '0;
        end else if (load) begin
            sh <= load_data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                sh <= {sh[WIDTH-2:0], 1'b0};
            end else begin
                sh <= {1'b0, sh[WIDTH-1:1]};
            end
        end
    end

    assign serial_bit = MSB_FIRST ? sh[WIDTH-1] : sh[0];

endmodule

// File: rtl/piso_serializer_tx.sv
// Parallel-in/serial-out transmitter with a one-deep pending buffer so that
// consecutive words leave back-to-back with no idle bit between them.
module piso_serializer_tx
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             D_OUT,
    output logic             FRAME,
    output logic             LAST,
    output logic             BUSY
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             ready_q;

    logic             accept;
    logic             last_bit;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_load_data;
    logic             serial_bit;

    // READY is registered, so accept never depends combinationally on IN_VALID.
    assign accept   = IN_VALID && ready_q;
    assign last_bit = (cnt_q == CNT_LAST);
    assign IN_READY = ready_q;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (sh_load),
        .shift      (sh_shift),
        .load_data  (sh_load_data),
        .serial_bit (serial_bit)
    );

    // Control registers; READY tracks the pending-buffer state one edge later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ready_q     <= !pend_full_d;
        end
    end

    // Next-state: start, shift, reload from pending or from input, or go idle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_load_data = IN_DATA;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (accept) begin
                        pend_d      = IN_DATA;
                        pend_full_d = 1'b1;
                    end
                end else if (pend_full_q) begin
                    // READY was low this cycle, so no new word competes with the drain.
                    sh_load      = 1'b1;
                    sh_load_data = pend_q;
                    pend_full_d  = 1'b0;
                    cnt_d        = '0;
                end else if (accept) begin
                    // Word arriving on the last-bit edge goes straight to the shifter.
                    sh_load = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial-line outputs follow the state register so reset clears them at once.
    always_comb begin
        D_OUT = IDLE_LEVEL;
        FRAME = 1'b0;
        LAST  = 1'b0;
        if (state_q == SHIFT) begin
            D_OUT = serial_bit;
            FRAME = 1'b1;
            LAST  = last_bit;
        end
    end

    assign BUSY = (state_q == SHIFT) || pend_full_q;

endmodule
